// File: rtl/spi_slv_modport.sv
// SPI mode-0 slave that turns framed 32-bit register reads/writes into single-cycle register bus strobes.
// Build option: define SPI_ADDR_CHECK_EN to reject addresses >= ADDR_NUM (no strobe, status 0x03).
module spi_slv_modport #(
  parameter int ADDR_NUM    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [31:0] reg_rdata
);

  // Register bus: reg_we / reg_re are one-clk strobes with reg_addr (and reg_wdata) stable
  // during the strobe; there is no back-pressure, and reg_rdata is taken 2 clk after reg_re.
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_INSTR  = 4'd1;
  localparam logic [3:0] ST_GAP    = 4'd2;
  localparam logic [3:0] ST_ADDR   = 4'd3;
  localparam logic [3:0] ST_WDATA  = 4'd4;
  localparam logic [3:0] ST_RDUMMY = 4'd5;
  localparam logic [3:0] ST_WDUMMY = 4'd6;
  localparam logic [3:0] ST_RDATA  = 4'd7;
  localparam logic [3:0] ST_STATUS = 4'd8;
  localparam logic [3:0] ST_DONE   = 4'd9;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_BAD   = 2'd2;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic        sck_d, ss_d;
  logic        sck_s, ss_s, mosi_s;
  logic        sck_rise, sck_fall, ss_fall;
  logic [3:0]  state;
  logic [1:0]  op;
  logic [6:0]  edge_cnt, edge_n;
  logic [7:0]  instr_sr, instr_next, status_q;
  logic [31:0] addr_next, wdata_next, rdata_q;
  logic        rd_d1, is_bad, addr_over, addr_err;

  // The ss chain resets low so that a reset inside a frame waits for a fresh ss_n fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign ss_s       = ss_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_d;
  assign sck_fall   = ~sck_s & sck_d;
  assign ss_fall    = ~ss_s & ss_d;
  assign edge_n     = edge_cnt + 7'd1;
  assign instr_next = {instr_sr[6:0], mosi_s};
  assign addr_next  = {reg_addr[30:0], mosi_s};
  assign wdata_next = {reg_wdata[30:0], mosi_s};
  assign is_bad     = (op == OP_BAD);

`ifdef SPI_ADDR_CHECK_EN
  assign addr_over = (addr_next >= 32'(ADDR_NUM));
`else
  assign addr_over = (ADDR_NUM < 0);
`endif
  assign addr_err = addr_over & ~is_bad;

  // State names the field that the next rising sck edge belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op        <= OP_BAD;
      edge_cnt  <= '0;
      instr_sr  <= '0;
      status_q  <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      rdata_q   <= '0;
      rd_d1     <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      miso      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      rd_d1  <= reg_re;
      if (rd_d1) rdata_q <= reg_rdata;
      if (ss_s) begin
        state <= ST_IDLE;
        miso  <= 1'b0;
      end else if (ss_fall) begin
        state     <= ST_INSTR;
        op        <= OP_BAD;
        edge_cnt  <= '0;
        instr_sr  <= '0;
        status_q  <= '0;
        reg_addr  <= '0;
        reg_wdata <= '0;
        rdata_q   <= '0;
        miso      <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (sck_rise && state != ST_DONE) begin
          edge_cnt <= edge_n;
          case (state)
            ST_INSTR: begin
              instr_sr <= instr_next;
              if (edge_n == 7'd8) begin
                state <= ST_GAP;
                if (instr_next == 8'h00)      op <= OP_WRITE;
                else if (instr_next == 8'h01) op <= OP_READ;
                else                          op <= OP_BAD;
              end
            end
            ST_GAP: state <= ST_ADDR;
            ST_ADDR: begin
              reg_addr <= addr_next;
              if (edge_n == 7'd41) begin
                status_q <= {5'b0, is_bad, addr_err, ~is_bad};
                if (op == OP_READ) begin
                  state  <= ST_RDUMMY;
                  reg_re <= ~addr_err;
                end else begin
                  state <= ST_WDATA;
                end
              end
            end
            ST_WDATA: begin
              if (op == OP_WRITE) reg_wdata <= wdata_next;
              if (edge_n == 7'd73) begin
                state  <= ST_WDUMMY;
                reg_we <= (op == OP_WRITE) & ~status_q[1];
              end
            end
            ST_RDUMMY: if (edge_n == 7'd48) state <= ST_RDATA;
            ST_WDUMMY, ST_RDATA: if (edge_n == 7'd80) state <= ST_STATUS;
            ST_STATUS: if (edge_n == 7'd88) state <= ST_DONE;
            default: ;
          endcase
        end
        if (sck_fall) begin
          case (state)
            ST_RDATA: begin
              miso    <= rdata_q[31];
              rdata_q <= {rdata_q[30:0], 1'b0};
            end
            ST_STATUS: begin
              miso     <= status_q[7];
              status_q <= {status_q[6:0], 1'b0};
            end
            default: miso <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slv_modport.sv
// Bench for spi_slv_modport: a bit-banged SPI master, a frame-level reference model and a strobe scoreboard.
module tb_spi_slv_modport;

  localparam int HALF     = 6;
  localparam int ADDR_NUM = 16;
`ifdef SPI_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [31:0] reg_addr, reg_wdata, reg_rdata;
  logic        reg_we, reg_re;

  int n_checks = 0;
  int n_fail   = 0;
  int extra_ones;
  logic [87:0] miso_bits, exp_miso;
  logic [31:0] rd_value = 32'h0;
  logic [63:0] exp_we_q[$], act_we_q[$];
  logic [31:0] exp_re_q[$], act_re_q[$];

  spi_slv_modport #(.ADDR_NUM(ADDR_NUM), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Register-side slave: records strobes and answers reads; junk on reg_rdata between frames.
  always @(negedge clk) begin
    if (reg_we) act_we_q.push_back({reg_addr, reg_wdata});
    if (reg_re) begin
      act_re_q.push_back(reg_addr);
      reg_rdata = rd_value;
    end else if (ss_n) begin
      reg_rdata = $urandom;
    end
  end

  function automatic logic [87:0] frame_bits(input logic [7:0] instr, input logic [31:0] addr,
                                             input logic [31:0] wdata);
    logic [14:0] pad;
    pad = 15'($urandom);
    return {instr, 1'b0, addr, wdata, pad};
  endfunction

  // Frame-level model: what the master must see on miso and which strobes must appear.
  task automatic model_frame(input logic [7:0] instr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int n_edges);
    bit is_wr, is_rd, err;
    is_wr = (instr == 8'h00);
    is_rd = (instr == 8'h01);
    err   = CHK && (is_wr || is_rd) && (addr >= ADDR_NUM);
    exp_miso = '0;
    exp_miso[7:0] = !(is_wr || is_rd) ? 8'h04 : (err ? 8'h03 : 8'h01);
    if (is_rd && !err) exp_miso[39:8] = rdata;
    for (int r = n_edges + 1; r <= 88; r++) exp_miso[88-r] = 1'b0;
    if (is_wr && !err && n_edges >= 73) exp_we_q.push_back({addr, wdata});
    if (is_rd && !err && n_edges >= 41) exp_re_q.push_back(addr);
  endtask

  task automatic run_frame(input logic [87:0] bits, input int n_edges, input int rst_at);
    miso_bits  = '0;
    extra_ones = 0;
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int r = 1; r <= n_edges; r++) begin
      mosi = (r <= 88) ? bits[88-r] : 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      if (r <= 88) miso_bits[88-r] = miso;
      else if (miso !== 1'b0) extra_ones++;
      sck = 1'b1;
      if (r == rst_at) begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", miso); end
    n_checks++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", reg_we); end
    n_checks++; if (reg_re !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b expected 0", reg_re); end
    n_checks++; if (reg_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", reg_addr); end
    n_checks++; if (reg_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", reg_wdata); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL post_reset_miso: got %b expected 0", miso); end
    n_checks++;
    if (act_we_q.size() != 0 || act_re_q.size() != 0) begin
      n_fail++; $display("FAIL post_reset_strobes: got we=%0d re=%0d expected 0 0", act_we_q.size(), act_re_q.size());
    end
  endtask

  // Directed frames from the plan; each row is instr, addr, wdata, rdata, edges run, reset edge.
  task automatic test_directed();
    logic [7:0]  ins  [9] = '{8'h00, 8'h01, 8'h7F, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
    logic [31:0] adr  [9] = '{32'h4, 32'h4, 32'h4, 32'h9, 32'h0, 32'h4, 32'h1, 32'h10, 32'h10};
    logic [31:0] wdt  [9] = '{32'hA5A5_1234, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'h0,
                              32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0};
    logic [31:0] rdt  [9] = '{32'h0, 32'hA5A5_1234, 32'h5555_AAAA, 32'h0, 32'h3C3C_C3C3, 32'h8765_4321,
                              32'h0, 32'h0, 32'hDEAD_BEEF};
    int          nrun [9] = '{88, 88, 88, 29, 88, 88, 88, 88, 88};
    int          rsta [9] = '{0, 0, 0, 0, 0, 45, 0, 0, 0};
    logic [63:0] we_a, we_e;
    logic [31:0] re_a, re_e;
    for (int i = 0; i < 9; i++) begin
      rd_value = rdt[i];
      model_frame(ins[i], adr[i], wdt[i], rdt[i], (rsta[i] > 0) ? rsta[i] : nrun[i]);
      run_frame(frame_bits(ins[i], adr[i], wdt[i]), nrun[i], rsta[i]);
      n_checks++;
      if (miso_bits !== exp_miso) begin
        n_fail++; $display("FAIL directed_miso[%0d]: got %h expected %h", i, miso_bits, exp_miso);
      end
      n_checks++;
      if (act_we_q.size() != exp_we_q.size() || act_re_q.size() != exp_re_q.size()) begin
        n_fail++; $display("FAIL directed_strobes[%0d]: got we=%0d re=%0d expected we=%0d re=%0d", i,
                           act_we_q.size(), act_re_q.size(), exp_we_q.size(), exp_re_q.size());
      end
      while (act_we_q.size() > 0 && exp_we_q.size() > 0) begin
        we_a = act_we_q.pop_front(); we_e = exp_we_q.pop_front(); n_checks++;
        if (we_a !== we_e) begin n_fail++; $display("FAIL directed_we[%0d]: got %h expected %h", i, we_a, we_e); end
      end
      while (act_re_q.size() > 0 && exp_re_q.size() > 0) begin
        re_a = act_re_q.pop_front(); re_e = exp_re_q.pop_front(); n_checks++;
        if (re_a !== re_e) begin n_fail++; $display("FAIL directed_re[%0d]: got %h expected %h", i, re_a, re_e); end
      end
      act_we_q.delete(); exp_we_q.delete(); act_re_q.delete(); exp_re_q.delete();
    end
  endtask

  task automatic test_extra_edges();
    logic [63:0] we_a;
    logic [31:0] wd;
    wd = $urandom;
    model_frame(8'h00, 32'h3, wd, 32'h0, 88);
    run_frame(frame_bits(8'h00, 32'h3, wd), 92, 0);
    n_checks++; if (extra_ones != 0) begin n_fail++; $display("FAIL extra_miso: got %0d ones expected 0", extra_ones); end
    n_checks++;
    if (miso_bits !== exp_miso) begin n_fail++; $display("FAIL extra_frame_miso: got %h expected %h", miso_bits, exp_miso); end
    n_checks++;
    if (act_we_q.size() != 1 || act_re_q.size() != 0) begin
      n_fail++; $display("FAIL extra_strobes: got we=%0d re=%0d expected we=1 re=0", act_we_q.size(), act_re_q.size());
    end else begin
      we_a = act_we_q.pop_front(); n_checks++;
      if (we_a !== exp_we_q[0]) begin n_fail++; $display("FAIL extra_we: got %h expected %h", we_a, exp_we_q[0]); end
    end
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL idle_miso: got %b expected 0", miso); end
    act_we_q.delete(); exp_we_q.delete(); act_re_q.delete(); exp_re_q.delete();
  endtask

  task automatic test_random();
    logic [7:0]  ins;
    logic [31:0] adr, wdt;
    int          n;
    logic [63:0] we_a, we_e;
    logic [31:0] re_a, re_e;
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ins = 8'h00;
        4, 5, 6, 7: ins = 8'h01;
        default:    ins = 8'($urandom_range(2, 255));
      endcase
      adr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
      wdt = $urandom;
      rd_value = $urandom;
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 87)) : 88;
      model_frame(ins, adr, wdt, rd_value, n);
      run_frame(frame_bits(ins, adr, wdt), n, 0);
      n_checks++;
      if (miso_bits !== exp_miso) begin
        n_fail++; $display("FAIL random_miso[%0d]: got %h expected %h", i, miso_bits, exp_miso);
      end
      n_checks++;
      if (act_we_q.size() != exp_we_q.size() || act_re_q.size() != exp_re_q.size()) begin
        n_fail++; $display("FAIL random_strobes[%0d]: got we=%0d re=%0d expected we=%0d re=%0d", i,
                           act_we_q.size(), act_re_q.size(), exp_we_q.size(), exp_re_q.size());
      end
      while (act_we_q.size() > 0 && exp_we_q.size() > 0) begin
        we_a = act_we_q.pop_front(); we_e = exp_we_q.pop_front(); n_checks++;
        if (we_a !== we_e) begin n_fail++; $display("FAIL random_we[%0d]: got %h expected %h", i, we_a, we_e); end
      end
      while (act_re_q.size() > 0 && exp_re_q.size() > 0) begin
        re_a = act_re_q.pop_front(); re_e = exp_re_q.pop_front(); n_checks++;
        if (re_a !== re_e) begin n_fail++; $display("FAIL random_re[%0d]: got %h expected %h", i, re_a, re_e); end
      end
      act_we_q.delete(); exp_we_q.delete(); act_re_q.delete(); exp_re_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_extra_edges();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
